// File: rtl/mem_rr_sched.sv
// mem_rr_sched: round-robin scheduler for the shared main-memory port.
// Each grant is held until the memory ack arrives, or until the grantee drops
// its request. A requester that has waited too long takes priority over the
// round-robin order.
//
// state   | meaning
// IDLE    | no grant; issue one when a request is pending and not busy/inhibited
// GRANT   | gnt_out held; wait for an unmasked ack or a dropped request
// RELEASE | one cycle with gnt_out=0 so the machine can drop its request
`timescale 1ns/1ps
module mem_rr_sched #(
  parameter int N_REQ     = 4,
  parameter int AGE_WIDTH = 8,
  parameter int AGE_LIMIT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] reqs_in,
  input  logic             ack_in,
  input  logic             busy_in,
  input  logic             inhibit_in,
  output logic [N_REQ-1:0] gnt_out,
  output logic [31:0]      i_out,
  output logic             gnt_valid_out,
  output logic [31:0]      grants_out,
  output logic             starve_out,
  output logic             proto_err_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX   = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_LIM_V = AGE_WIDTH'(AGE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [31:0]          i_q, i_d;
  logic [31:0]          grants_q, grants_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 starve_q, starve_d;
  logic                 proto_err_q, proto_err_d;
  logic [AGE_WIDTH-1:0] age_q [N_REQ];
  logic [AGE_WIDTH-1:0] age_d [N_REQ];

  logic                 aged_found;
  logic [IDX_W-1:0]     aged_idx, rr_idx, win_idx, rr_probe;
  logic [IDX_W-1:0]     gidx;

  assign gidx = i_q[IDX_W-1:0];

  // Winner: lowest-index aged requester, else first requester after last_winner.
  always_comb begin
    aged_found = 1'b0;
    aged_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (reqs_in[IDX_W'(k)] && (age_q[IDX_W'(k)] >= AGE_LIM_V)) begin
        aged_found = 1'b1;
        aged_idx   = IDX_W'(k);
      end
    end
    rr_idx   = '0;
    rr_probe = '0;
    // Descending offsets so the nearest requester after last_winner is kept.
    for (int k = N_REQ; k >= 1; k--) begin
      rr_probe = IDX_W'((int'(last_q) + k) % N_REQ);
      if (reqs_in[rr_probe]) rr_idx = rr_probe;
    end
    win_idx = aged_found ? aged_idx : rr_idx;
  end

  // Per-requester wait counters and the sticky starvation flag.
  always_comb begin
    age_d    = age_q;
    starve_d = starve_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!reqs_in[IDX_W'(k)] || gnt_q[IDX_W'(k)]) age_d[IDX_W'(k)] = '0;
      else if (age_q[IDX_W'(k)] != AGE_MAX)        age_d[IDX_W'(k)] = age_q[IDX_W'(k)] + 1'b1;
      else                                         age_d[IDX_W'(k)] = AGE_MAX;
      if (age_d[IDX_W'(k)] == AGE_MAX) starve_d = 1'b1;
    end
  end

  // Grant FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    i_d         = i_q;
    grants_d    = grants_q;
    last_d      = last_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if ((reqs_in != '0) && !busy_in && !inhibit_in) begin
          gnt_d   = N_REQ'(1) << win_idx;
          i_d     = 32'(win_idx);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Ack wins over a simultaneous request drop.
        if (ack_in && !inhibit_in) begin
          grants_d = grants_q + 32'd1;
          last_d   = gidx;
          gnt_d    = '0;
          state_d  = RELEASE;
        end else if (!reqs_in[gidx]) begin
          proto_err_d = 1'b1;
          gnt_d       = '0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      i_q         <= '0;
      grants_q    <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      starve_q    <= 1'b0;
      proto_err_q <= 1'b0;
      for (int k = 0; k < N_REQ; k++) age_q[IDX_W'(k)] <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      i_q         <= i_d;
      grants_q    <= grants_d;
      last_q      <= last_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
      for (int k = 0; k < N_REQ; k++) age_q[IDX_W'(k)] <= age_d[IDX_W'(k)];
    end
  end

  assign gnt_out       = gnt_q;
  assign i_out         = i_q;
  assign gnt_valid_out = |gnt_q;
  assign grants_out    = grants_q;
  assign starve_out    = starve_q;
  assign proto_err_out = proto_err_q;

endmodule

// File: tb/tb_mem_rr_sched.sv
// Testbench for mem_rr_sched: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_rr_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  reqs = '0;
  logic        ack = 1'b0, busy = 1'b0, inh = 1'b0;
  logic [3:0]  gnt_out;
  logic [31:0] i_out, grants_out;
  logic        gnt_valid_out, starve_out, proto_err_out;
  logic [70:0] act_vec;

  int n_checks = 0;
  int n_pass   = 0;

  mem_rr_sched dut (
    .clock(clock), .reset(reset), .reqs_in(reqs), .ack_in(ack), .busy_in(busy),
    .inhibit_in(inh), .gnt_out(gnt_out), .i_out(i_out), .gnt_valid_out(gnt_valid_out),
    .grants_out(grants_out), .starve_out(starve_out), .proto_err_out(proto_err_out)
  );

  always #5 clock = ~clock;

  assign act_vec = {gnt_out, i_out, gnt_valid_out, grants_out, starve_out, proto_err_out};

  // Reference model: granted (holder index) / cooling-off / free, plus
  // wait times, a completion count and two sticky flags.
  int          m_phase;   // 0 free, 1 someone holds the port, 2 cooling off
  int          m_gidx, m_idx, m_last, m_gcnt;
  int          m_age [4];
  logic [31:0] m_grants;
  logic        m_starve, m_perr;

  function automatic int pick();
    for (int k = 0; k < 4; k++) if (reqs[k] && m_age[k] >= 64) return k;
    for (int k = 1; k <= 4; k++) if (reqs[(m_last + k) % 4]) return (m_last + k) % 4;
    return 0;
  endfunction

  function automatic logic [70:0] exp_vec();
    logic [3:0] g;
    g = (m_phase == 1) ? 4'(1 << m_gidx) : 4'b0;
    return {g, 32'(m_idx), m_phase == 1, m_grants, m_starve, m_perr};
  endfunction

  always @(posedge clock) begin
    int old_g;
    old_g = (m_phase == 1) ? m_gidx : -1;
    if (reset) begin
      m_phase = 0; m_gidx = 0; m_idx = 0; m_last = 3; m_gcnt = 0;
      m_grants = '0; m_starve = 1'b0; m_perr = 1'b0;
      for (int k = 0; k < 4; k++) m_age[k] = 0;
    end else begin
      if (m_phase == 0) begin
        if (reqs != 0 && !busy && !inh) begin
          m_gidx = pick(); m_idx = m_gidx; m_gcnt = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_gcnt++;
        if (ack && !inh) begin
          m_grants = m_grants + 1; m_last = m_gidx; m_phase = 2;
        end else if (!reqs[m_gidx]) begin
          m_perr = 1'b1; m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      for (int k = 0; k < 4; k++) begin
        if (!reqs[k] || k == old_g) m_age[k] = 0;
        else if (m_age[k] < 255)    m_age[k]++;
        if (m_age[k] == 255) m_starve = 1'b1;
      end
    end
  end

  // Advance one cycle; ack pulses d cycles after the grant became visible.
  task automatic tick(input int d);
    @(posedge clock);
    @(negedge clock);
    ack = (d > 0 && m_phase == 1 && m_gcnt == d - 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1; ack = 1'b0; busy = 1'b0; inh = 1'b0; reqs = '0;
    tick(0); tick(0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (act_vec !== 71'b0) $display("FAIL reset_values: got %h want %h", act_vec, 71'b0);
    else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    reqs = 4'b0001;
    tick(3);
    n_checks++;
    if (gnt_out !== 4'b0001) $display("FAIL single_latency: got %b want %b", gnt_out, 4'b0001);
    else n_pass++;
    repeat (30) begin
      tick(3);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL single_model: got %h want %h", act_vec, exp_vec());
      else n_pass++;
      n_checks++;
      if (i_out !== 32'd0) $display("FAIL single_index: got %0d want 0", i_out);
      else n_pass++;
    end
  endtask

  task automatic test_all_rr();
    int order [5] = '{0, 1, 2, 3, 0};
    int seen = 0;
    logic prev = 1'b0;
    apply_reset();
    reqs = 4'b1111;
    repeat (19) begin
      tick(2);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL rr_model: got %h want %h", act_vec, exp_vec());
      else n_pass++;
      if (gnt_valid_out && !prev && seen < 5) begin
        n_checks++;
        if (i_out !== 32'(order[seen])) $display("FAIL rr_order: got %0d want %0d", i_out, order[seen]);
        else n_pass++;
        seen++;
      end
      prev = gnt_valid_out;
    end
    n_checks++;
    if (seen !== 5) $display("FAIL rr_grant_count: got %0d want 5", seen);
    else n_pass++;
    n_checks++;
    if (grants_out !== 32'd5) $display("FAIL rr_acks: got %0d want 5", grants_out);
    else n_pass++;
  endtask

  task automatic test_skip();
    int order [4] = '{0, 1, 3, 0};
    int seen = 0;
    logic prev = 1'b0;
    apply_reset();
    reqs = 4'b1011;
    repeat (15) begin
      tick(2);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL skip_model: got %h want %h", act_vec, exp_vec());
      else n_pass++;
      if (gnt_valid_out && !prev && seen < 4) begin
        n_checks++;
        if (i_out !== 32'(order[seen])) $display("FAIL skip_order: got %0d want %0d", i_out, order[seen]);
        else n_pass++;
        seen++;
      end
      prev = gnt_valid_out;
    end
    n_checks++;
    if (seen !== 4) $display("FAIL skip_grant_count: got %0d want 4", seen);
    else n_pass++;
  endtask

  task automatic test_inhibit();
    apply_reset();
    inh = 1'b1; reqs = 4'b0010;
    repeat (5) tick(0);
    n_checks++;
    if (gnt_out !== 4'b0000) $display("FAIL inhibit_idle: got %b want %b", gnt_out, 4'b0000);
    else n_pass++;
    inh = 1'b0;
    tick(0);
    n_checks++;
    if (gnt_out !== 4'b0010) $display("FAIL inhibit_release: got %b want %b", gnt_out, 4'b0010);
    else n_pass++;
    inh = 1'b1; ack = 1'b1;
    tick(0);
    tick(0);
    n_checks++;
    if ({gnt_out, grants_out} !== {4'b0010, 32'd0})
      $display("FAIL inhibit_ack_masked: got %b/%0d want 0010/0", gnt_out, grants_out);
    else n_pass++;
    inh = 1'b0; ack = 1'b1;
    tick(0);
    n_checks++;
    if ({gnt_out, grants_out} !== {4'b0000, 32'd1})
      $display("FAIL inhibit_ack_counted: got %b/%0d want 0000/1", gnt_out, grants_out);
    else n_pass++;
    n_checks++;
    if (act_vec !== exp_vec()) $display("FAIL inhibit_model: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_aging();
    apply_reset();
    reqs = 4'b0001;
    tick(0);
    reqs = 4'b1001;
    repeat (70) begin
      tick(0);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL aging_model: got %h want %h", act_vec, exp_vec());
      else n_pass++;
    end
    reqs = 4'b1101;
    tick(0); tick(0);
    ack = 1'b1;
    tick(0);
    tick(0);
    tick(0);
    n_checks++;
    if ({gnt_out, i_out} !== {4'b1000, 32'd3})
      $display("FAIL aging_winner: got %b/%0d want 1000/3", gnt_out, i_out);
    else n_pass++;
    n_checks++;
    if (act_vec !== exp_vec()) $display("FAIL aging_model_win: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_starve();
    n_checks++;
    if (starve_out !== 1'b0) $display("FAIL starve_early: got %b want 0", starve_out);
    else n_pass++;
    repeat (260) begin
      tick(0);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL starve_model: got %h want %h", act_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (starve_out !== 1'b1) $display("FAIL starve_set: got %b want 1", starve_out);
    else n_pass++;
    reqs = 4'b0000;
    repeat (5) tick(0);
    n_checks++;
    if (starve_out !== 1'b1) $display("FAIL starve_sticky: got %b want 1", starve_out);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (starve_out !== 1'b0) $display("FAIL starve_reset: got %b want 0", starve_out);
    else n_pass++;
  endtask

  task automatic test_proto_err();
    apply_reset();
    reqs = 4'b0100;
    tick(0); tick(0);
    reqs = 4'b0000;
    tick(0);
    n_checks++;
    if ({proto_err_out, gnt_out, grants_out} !== {1'b1, 4'b0000, 32'd0})
      $display("FAIL proto_drop: got %b/%b/%0d want 1/0000/0", proto_err_out, gnt_out, grants_out);
    else n_pass++;
    tick(0);
    n_checks++;
    if (act_vec !== exp_vec()) $display("FAIL proto_model: got %h want %h", act_vec, exp_vec());
    else n_pass++;
    apply_reset();
    reqs = 4'b0100;
    tick(0);
    reqs = 4'b0000; ack = 1'b1;
    tick(0);
    n_checks++;
    if ({proto_err_out, grants_out} !== {1'b0, 32'd1})
      $display("FAIL proto_ack_wins: got %b/%0d want 0/1", proto_err_out, grants_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    reqs = 4'b1111;
    tick(0);
    n_checks++;
    if (gnt_valid_out !== 1'b1) $display("FAIL midreset_granted: got %b want 1", gnt_valid_out);
    else n_pass++;
    reset = 1'b1; ack = 1'b1;
    tick(0);
    n_checks++;
    if (act_vec !== 71'b0) $display("FAIL midreset_values: got %h want %h", act_vec, 71'b0);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    repeat (1500) begin
      tick(0);
      if ($urandom_range(7) == 0) reqs = 4'($urandom);
      ack  = ($urandom_range(3) == 0);
      busy = ($urandom_range(4) == 0);
      inh  = ($urandom_range(5) == 0);
      n_checks++;
      if (act_vec !== exp_vec()) $display("FAIL random_model: got %h want %h", act_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_skip();
    test_inhibit();
    test_aging();
    test_starve();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_rr_sched.md
Name: mem_rr_sched

Overview:
- Shares the single main memory port between N freemachine requesters.
- Replaces the plain request arbiter with a round-robin scheduler that locks each grant until the memory ack and respects testbench staging.
- Adds an aging override so no machine starves, plus completion and protocol-error reporting.
- Sits between the machine reqs vector, the mem ack/busy outputs and the top-level address/data muxes, which use the grant index to select.

Parameters:
N_REQ, 4, number of requesters (equals machine count).
AGE_WIDTH, 8, width of each per-requester wait counter.
AGE_LIMIT, 64, wait-cycle count at or above which a requester gets priority over the round-robin order.

Ports:
clock  input  1  clock.
reset  input  1  synchronous, active-high reset.
reqs_in  input  N_REQ  per-requester request level; bit high = read or write pending.
ack_in  input  1  memory ack, one-cycle pulse.
busy_in  input  1  memory busy; no new grant issued while high.
inhibit_in  input  1  testbench staging; blocks new grants and masks ack_in.
gnt_out  output  N_REQ  one-hot grant, registered.
i_out  output  32  index of current or most recent grant.
gnt_valid_out  output  1  high exactly when gnt_out is nonzero.
grants_out  output  32  count of completed (acked) grants.
starve_out  output  1  sticky; set when any age counter saturates at its all-ones value.
proto_err_out  output  1  sticky; set when a granted requester drops its req before ack.

Behaviour:
- Reset values: gnt_out=0, i_out=0, gnt_valid_out=0, grants_out=0, starve_out=0, proto_err_out=0, all age counters=0, last_winner=N_REQ-1, state=IDLE.
- Reset mid-grant aborts the grant immediately. No ack is counted.
- FSM states:
  - IDLE: if reqs_in!=0 and !busy_in and !inhibit_in, choose a winner, load gnt_out/i_out, and go to GRANT. gnt_out is visible the cycle after the request is sampled (latency 1).
  - GRANT: gnt_out held constant.
    - If ack_in && !inhibit_in: increment grants_out, set last_winner=i_out, and go to RELEASE.
    - Else if reqs_in[i_out]==0: set proto_err_out and go to RELEASE without counting.
    - Else stay in GRANT.
  - RELEASE: gnt_out=0 for exactly one cycle and ack_in is ignored; then go to IDLE. This gap lets the machine drop its req after ack.
- Winner selection:
  - If any requester with reqs_in high has age >= AGE_LIMIT, the lowest such index wins.
  - Otherwise round-robin: first requester with reqs_in high searching from last_winner+1 upward, wrapping modulo N_REQ.
  - With a single requester, it wins every time.
- Age counters, per requester, updated every cycle:
  - Cleared when reqs_in is low or the requester is the current grantee.
  - Otherwise incremented, saturating at 2^AGE_WIDTH-1.
  - Reaching saturation sets starve_out. starve_out clears only on reset.
- inhibit_in:
  - Asserted in IDLE: no grant is issued.
  - Asserted in GRANT: the grant is held and ack_in is masked, so the ack belongs to the testbench.
  - Deasserted: normal operation resumes the same cycle.
- busy_in affects only the IDLE-to-GRANT transition. An existing grant is unaffected.
- i_out retains the last grantee while idle, so it is always a legal mux index.
- grants_out wraps modulo 2^32.
- Simultaneous ack_in and reqs_in drop in GRANT: the ack takes precedence, it is counted, and no error is flagged.

Test Plan:
1. Reset, then reqs_in=4'b0001 held; ack pulses 3 cycles after each grant -> gnt_out=0001 one cycle after req; grant, 1-cycle gap, grant repeat; grants_out increments by 1 per ack; i_out=0.
2. reqs_in=4'b1111 held, ack 2 cycles after each grant -> grant order 0,1,2,3,0 (last_winner reset = 3); one RELEASE cycle between grants; grants_out=5 after 5 acks.
3. reqs_in=4'b1011, last_winner=0 -> next winner 1, then 3, then 0 (wrap; index 2 skipped).
4. inhibit_in=1 with reqs_in=0010 -> no grant. inhibit_in=1 while granted and ack_in pulses -> grant held, grants_out unchanged. inhibit_in=0 then ack -> counted.
5. AGE_LIMIT=4, requester 3 held and ack delayed 10 cycles while requesters 1,2 are also held -> after current ack, winner is 3 ahead of round-robin. Age hitting 255 -> starve_out=1 until reset.
6. Granted requester drops req with no ack -> proto_err_out=1, RELEASE then IDLE, grants_out unchanged. Reset asserted mid-GRANT -> all outputs return to reset values next cycle.
